// File: rtl/spart_rx_fifo.sv
// spart_rx_fifo: receive byte FIFO between rx_unit and the SPART bus interface
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-low reset
//   rx_data      received byte from rx_unit, valid while rda=1
//   rda          rx_unit receive-data-available
//   clr_rda      one-cycle acknowledge pulse back to rx_unit
//   iocs         bus chip select
//   iorw         1=read, 0=write
//   ioaddr       00 DATA, 01 STATUS, 10 DB_LOW, 11 DB_HIGH
//   bus_rd_data  combinational read data, 8'h00 when not selected
//   rx_avail     FIFO not empty
//
// Build option: define RX_FIFO_DROP_OLDEST_EN to overwrite the oldest entry
// when a byte arrives while full (sets the sticky overflow status bit)
// instead of back-pressuring rx_unit.
module spart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rda,
    output logic       clr_rda,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    output logic [7:0] bus_rd_data,
    output logic       rx_avail
);
    localparam int PTR_W = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;
    state_t state, state_nxt;
    logic [7:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic overflow, full, empty, rd_data_sel, rd_stat_sel, pop, push, drop;
    assign full = count == CNT_W'(DEPTH);
    assign empty = count == '0;
    assign rx_avail = ~empty;
    assign rd_data_sel = iocs & iorw & (ioaddr == 2'b00);
    assign rd_stat_sel = iocs & iorw & (ioaddr == 2'b01);
    assign pop = rd_data_sel & ~empty;
    // clr_rda decodes straight from the state register so an async reset drops it at once
    assign clr_rda = state == ACK;
`ifdef RX_FIFO_DROP_OLDEST_EN
    // A full FIFO with no concurrent pop makes room by discarding the head
    assign push = (state == IDLE) & rda;
    assign drop = push & full & ~pop;
    always_ff @(posedge clk or negedge rst)
        if (!rst) overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
        else if (rd_stat_sel) overflow <= 1'b0;
`else
    // A pop on the same edge frees the slot, so a full FIFO can still accept
    assign push = (state == IDLE) & rda & (~full | pop);
    assign drop = 1'b0;
    assign overflow = 1'b0;
`endif
    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE) ? (push ? ACK : IDLE) :
                    (state == ACK)  ? WAIT_LOW :
                    (rda ? WAIT_LOW : IDLE);
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr + PTR_W'(push);
            rd_ptr <= rd_ptr + PTR_W'(pop | drop);
            count  <= count + CNT_W'(push) - CNT_W'(pop | drop);
        end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= rx_data;
    assign bus_rd_data = !rst        ? 8'h00 :
                         rd_data_sel ? (empty ? 8'h00 : mem[rd_ptr]) :
                         rd_stat_sel ? {overflow, full, empty, 5'(count)} :
                         8'h00;
endmodule
